// File: rtl/yc_noc_inject_arb_if.sv
// Flit encoding shared by the NoC endpoint, plus the requester/mesh/response
// bundle used by the injection arbiter.
package yc_noc_defs;
  localparam int FLIT_W = 32;
  typedef logic [FLIT_W-1:0] flit_t;

  // Flit layout: opc[31:28] dst_x[27:26] dst_y[25:24] src_x[23:22] src_y[21:20] payload[19:0]
  localparam logic [3:0] OP_WRITE     = 4'h1;
  localparam logic [3:0] OP_READ_REQ  = 4'h2;
  localparam logic [3:0] OP_READ_RESP = 4'h3;
  localparam logic [3:0] OP_MSG       = 4'h4;

  function automatic logic [3:0] get_opc(flit_t f);
    return f[31:28];
  endfunction
  function automatic logic [1:0] get_dst_x(flit_t f);
    return f[27:26];
  endfunction
  function automatic logic [1:0] get_dst_y(flit_t f);
    return f[25:24];
  endfunction
  function automatic logic [1:0] get_src_x(flit_t f);
    return f[23:22];
  endfunction
  function automatic logic [1:0] get_src_y(flit_t f);
    return f[21:20];
  endfunction
endpackage

interface yc_noc_inject_arb_if #(parameter int N_REQ = 2);
  import yc_noc_defs::*;

  logic  [N_REQ-1:0] req_valid;
  flit_t [N_REQ-1:0] req_flit;
  logic  [N_REQ-1:0] req_ready;
  logic              noc_tx_valid;
  flit_t             noc_tx_flit;
  logic              noc_tx_ready;
  logic              noc_rx_valid;
  flit_t             noc_rx_flit;
  logic              noc_rx_ready;
  logic  [N_REQ-1:0] rsp_valid;
  flit_t             rsp_flit;
  logic  [N_REQ-1:0] rsp_ready;

  modport slave (
    input  req_valid, req_flit, noc_tx_ready, noc_rx_valid, noc_rx_flit, rsp_ready,
    output req_ready, noc_tx_valid, noc_tx_flit, noc_rx_ready, rsp_valid, rsp_flit
  );
  modport master (
    output req_valid, req_flit, noc_tx_ready, noc_rx_valid, noc_rx_flit, rsp_ready,
    input  req_ready, noc_tx_valid, noc_tx_flit, noc_rx_ready, rsp_valid, rsp_flit
  );
endinterface

// File: rtl/yc_noc_inject_arb.sv
// Round-robin injection arbiter onto the mesh local port, with an ID FIFO that
// routes read responses back to their requester under a single-destination lock.
module yc_noc_inject_arb
  import yc_noc_defs::*;
#(
  parameter int N_REQ   = 2,
  parameter int MAX_OUT = 4,
  parameter int ID_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int CNT_W  = $clog2(MAX_OUT + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  yc_noc_inject_arb_if.slave   bus,
  output logic [CNT_W-1:0]     out_cnt,
  output logic                 err_unexpected
);
  localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  logic             tx_valid_q, tx_valid_d;
  flit_t            tx_flit_q, tx_flit_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [3:0]       lock_dst_q, lock_dst_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             err_q, err_d;
  logic [ID_W-1:0]  id_mem [MAX_OUT];

  logic [N_REQ-1:0] is_read, eligible, req_ready, rsp_valid;
  logic             cnt_zero, slot_free, load_ok, accept, push, pop, drop;
  logic             grant_found, rsp_expected, rx_ready;
  logic [ID_W-1:0]  grant_id, head_id;
  logic [ID_W:0]    scan_sum;
  logic [ID_W-1:0]  scan_idx;
  flit_t            grant_flit;

  assign cnt_zero  = (out_cnt_q == '0);
  assign slot_free = (out_cnt_q < CNT_W'(MAX_OUT));

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_elig
    assign is_read[gi]  = (get_opc(bus.req_flit[gi]) == OP_READ_REQ);
    // A read may only join the outstanding set if it targets the locked node.
    assign eligible[gi] = bus.req_valid[gi] &&
                          (!is_read[gi] ||
                           (slot_free && (cnt_zero ||
                            {get_dst_x(bus.req_flit[gi]), get_dst_y(bus.req_flit[gi])} == lock_dst_q)));
    assign req_ready[gi] = accept && (grant_id == ID_W'(gi));
  end

  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    scan_sum    = '0;
    scan_idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      scan_idx = (scan_sum >= (ID_W+1)'(N_REQ)) ? ID_W'(scan_sum - (ID_W+1)'(N_REQ))
                                                 : ID_W'(scan_sum);
      if (!grant_found && eligible[scan_idx]) begin
        grant_found = 1'b1;
        grant_id    = scan_idx;
      end
    end
  end

  assign grant_flit = bus.req_flit[grant_id];
  assign load_ok    = !tx_valid_q || bus.noc_tx_ready;
  assign accept     = grant_found && load_ok && !rst;
  assign push       = accept && is_read[grant_id];

  assign head_id      = id_mem[rd_ptr_q];
  assign rsp_expected = bus.noc_rx_valid &&
                        (get_opc(bus.noc_rx_flit) == OP_READ_RESP) && !cnt_zero &&
                        ({get_src_x(bus.noc_rx_flit), get_src_y(bus.noc_rx_flit)} == lock_dst_q);

  always_comb begin
    rsp_valid = '0;
    rx_ready  = 1'b0;
    if (!rst) begin
      if (rsp_expected) begin
        rsp_valid[head_id] = 1'b1;
        rx_ready           = bus.rsp_ready[head_id];
      end else begin
        rx_ready = 1'b1;
      end
    end
  end

  assign pop  = rsp_expected && bus.rsp_ready[head_id] && !rst;
  assign drop = bus.noc_rx_valid && !rsp_expected && !rst;

  always_comb begin
    tx_valid_d = tx_valid_q;
    tx_flit_d  = tx_flit_q;
    rr_ptr_d   = rr_ptr_q;
    lock_dst_d = lock_dst_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    out_cnt_d  = out_cnt_q;
    err_d      = drop;
    if (accept) begin
      tx_valid_d = 1'b1;
      tx_flit_d  = grant_flit;
      rr_ptr_d   = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
    end else if (bus.noc_tx_ready) begin
      tx_valid_d = 1'b0;
    end
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(MAX_OUT - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (cnt_zero) lock_dst_d = {get_dst_x(grant_flit), get_dst_y(grant_flit)};
    end
    if (pop) rd_ptr_d = (rd_ptr_q == PTR_W'(MAX_OUT - 1)) ? '0 : rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   out_cnt_d = out_cnt_q + 1'b1;
      2'b01:   out_cnt_d = out_cnt_q - 1'b1;
      default: out_cnt_d = out_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_valid_q <= 1'b0;
      tx_flit_q  <= '0;
      out_cnt_q  <= '0;
      rr_ptr_q   <= '0;
      lock_dst_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      tx_valid_q <= tx_valid_d;
      tx_flit_q  <= tx_flit_d;
      out_cnt_q  <= out_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_dst_q <= lock_dst_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) id_mem[wr_ptr_q] <= grant_id;
  end

  assign bus.req_ready    = req_ready;
  assign bus.noc_tx_valid = tx_valid_q;
  assign bus.noc_tx_flit  = tx_flit_q;
  assign bus.noc_rx_ready = rx_ready;
  assign bus.rsp_valid    = rsp_valid;
  assign bus.rsp_flit     = bus.noc_rx_flit;
  assign out_cnt          = out_cnt_q;
  assign err_unexpected   = err_q;
endmodule

// File: tb/tb_yc_noc_inject_arb.sv
// Bench for yc_noc_inject_arb: directed scenarios with literal expectations, then
// randomized traffic, all compared every cycle against a queue-based model.
module tb_yc_noc_inject_arb;
  import yc_noc_defs::*;
  localparam int N  = 2;
  localparam int M  = 4;
  localparam int CW = $clog2(M + 1);

  logic clk = 1'b0;
  logic rst;
  logic [CW-1:0] out_cnt;
  logic err;
  always #5 clk = ~clk;

  yc_noc_inject_arb_if #(.N_REQ(N)) bus();
  yc_noc_inject_arb #(.N_REQ(N), .MAX_OUT(M)) dut (
    .clk(clk), .rst(rst), .bus(bus), .out_cnt(out_cnt), .err_unexpected(err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // model state
  bit         m_known = 0;
  bit         m_txv = 0;
  flit_t      m_txf = '0;
  int         m_ids[$];
  logic [3:0] m_lock = '0;
  int         m_rr = 0;
  bit         m_err = 0;
  logic [N-1:0] m_acc = '0;
  bit         m_rxtake = 0;

  // actual DUT values sampled at the last compare point
  logic [N-1:0] a_rr, a_rspv;
  logic a_rxr, a_txv, a_err;
  flit_t a_txf;
  logic [CW-1:0] a_cnt;

  // stimulus state
  typedef struct { flit_t f; int due; } rx_item_t;
  rx_item_t rxq[$];
  bit    pend[N];
  flit_t pflit[N];
  bit    rx_cur_v = 0;
  flit_t rx_cur = '0;
  int p_req = 60, p_txr = 75, p_rspr = 70, p_unexp = 5;

  function automatic flit_t mkf(logic [3:0] op, logic [1:0] dx, logic [1:0] dy,
                                logic [1:0] sx, logic [1:0] sy, logic [19:0] pl);
    return {op, dx, dy, sx, sy, pl};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic cyc_step();
    logic [N-1:0] e_rr, e_rv;
    logic e_rxr;
    bit exp_rsp, acc;
    int g, cnt0, idx;
    flit_t f;
    @(negedge clk);
    a_rr = bus.req_ready; a_rspv = bus.rsp_valid; a_rxr = bus.noc_rx_ready;
    a_txv = bus.noc_tx_valid; a_txf = bus.noc_tx_flit; a_cnt = out_cnt; a_err = err;
    if (m_known) begin
      chk("tx_valid", a_txv, m_txv);
      chk("tx_flit", a_txf, m_txf);
      chk("out_cnt", a_cnt, m_ids.size());
      chk("err_unexpected", a_err, m_err);
    end
    if (rst) begin
      chk("rst_req_ready", a_rr, 0);
      chk("rst_rsp_valid", a_rspv, 0);
      chk("rst_rx_ready", a_rxr, 0);
      m_txv = 0; m_txf = '0; m_ids.delete(); m_lock = '0; m_rr = 0; m_err = 0;
      m_acc = '0; m_rxtake = 0; m_known = 1;
    end else begin
      cnt0 = m_ids.size();
      g = -1;
      for (int k = 0; k < N; k++) begin
        idx = (m_rr + k) % N;
        f = bus.req_flit[idx];
        if (g < 0 && bus.req_valid[idx] &&
            (get_opc(f) != OP_READ_REQ ||
             (cnt0 < M && (cnt0 == 0 || {get_dst_x(f), get_dst_y(f)} == m_lock))))
          g = idx;
      end
      acc = (g >= 0) && (!m_txv || bus.noc_tx_ready);
      e_rr = '0;
      if (acc) e_rr[g] = 1'b1;
      f = bus.noc_rx_flit;
      exp_rsp = bus.noc_rx_valid && get_opc(f) == OP_READ_RESP && cnt0 > 0 &&
                {get_src_x(f), get_src_y(f)} == m_lock;
      e_rv = '0;
      e_rxr = 1'b1;
      if (exp_rsp) begin
        e_rv[m_ids[0]] = 1'b1;
        e_rxr = bus.rsp_ready[m_ids[0]];
      end
      chk("req_ready", a_rr, e_rr);
      chk("rsp_valid", a_rspv, e_rv);
      if (bus.noc_rx_valid) begin
        chk("noc_rx_ready", a_rxr, e_rxr);
        chk("rsp_flit", bus.rsp_flit, f);
      end
      // the mesh side of the bench answers each read that leaves the tx register
      if (m_txv && bus.noc_tx_ready && get_opc(m_txf) == OP_READ_REQ)
        rxq.push_back('{mkf(OP_READ_RESP, 2'd0, 2'd0, get_dst_x(m_txf), get_dst_y(m_txf),
                            20'(cyc)), cyc + $urandom_range(1, 12)});
      if (acc) begin
        m_txv = 1; m_txf = bus.req_flit[g]; m_rr = (g + 1) % N;
        if (get_opc(m_txf) == OP_READ_REQ) begin
          if (cnt0 == 0) m_lock = {get_dst_x(m_txf), get_dst_y(m_txf)};
          m_ids.push_back(g);
        end
      end else if (bus.noc_tx_ready) m_txv = 0;
      if (exp_rsp && bus.rsp_ready[m_ids[0]]) void'(m_ids.pop_front());
      m_err = bus.noc_rx_valid && !exp_rsp;
      m_acc = e_rr;
      m_rxtake = bus.noc_rx_valid && e_rxr;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive();
    logic [1:0] dx, dy;
    int d;
    for (int i = 0; i < N; i++) begin
      if (m_acc[i]) pend[i] = 0;
      if (!pend[i] && ($urandom % 100) < p_req) begin
        d = $urandom % 3;
        dx = (d == 1) ? 2'd2 : (d == 0) ? 2'd1 : 2'd0;
        dy = (d == 2) ? 2'd1 : 2'd0;
        pend[i] = 1;
        pflit[i] = mkf(($urandom % 2) ? OP_READ_REQ : (($urandom % 2) ? OP_WRITE : OP_MSG),
                       dx, dy, 2'd0, 2'd0, 20'($urandom));
      end
      bus.req_valid[i] = pend[i];
      bus.req_flit[i]  = pflit[i];
      bus.rsp_ready[i] = ($urandom % 100) < p_rspr;
    end
    if (m_rxtake) rx_cur_v = 0;
    if (!rx_cur_v) begin
      if (rxq.size() > 0 && rxq[0].due <= cyc) begin
        rx_cur = rxq[0].f; rx_cur_v = 1;
        void'(rxq.pop_front());
      end else if (($urandom % 100) < p_unexp) begin
        rx_cur = mkf(($urandom % 2) ? OP_READ_RESP : OP_WRITE, 2'd0, 2'd0, 2'd3, 2'd3,
                     20'($urandom));
        rx_cur_v = 1;
      end
    end
    bus.noc_rx_valid = rx_cur_v;
    bus.noc_rx_flit  = rx_cur;
    bus.noc_tx_ready = ($urandom % 100) < p_txr;
  endtask

  flit_t w0, w1, rd10, rd20, rs10, rs20;

  initial begin
    w0   = mkf(OP_WRITE, 2'd1, 2'd0, 2'd0, 2'd0, 20'hA);
    w1   = mkf(OP_WRITE, 2'd1, 2'd0, 2'd0, 2'd0, 20'hB);
    rd10 = mkf(OP_READ_REQ, 2'd1, 2'd0, 2'd0, 2'd0, 20'h11);
    rd20 = mkf(OP_READ_REQ, 2'd2, 2'd0, 2'd0, 2'd0, 20'h12);
    rs10 = mkf(OP_READ_RESP, 2'd0, 2'd0, 2'd1, 2'd0, 20'h22);
    rs20 = mkf(OP_READ_RESP, 2'd0, 2'd0, 2'd2, 2'd0, 20'h23);
    rst = 1'b1;
    bus.req_valid = '0; bus.req_flit[0] = '0; bus.req_flit[1] = '0;
    bus.noc_tx_ready = 1'b1; bus.noc_rx_valid = 1'b0; bus.noc_rx_flit = '0;
    bus.rsp_ready = 2'b11;
    repeat (3) cyc_step();
    rst = 1'b0;
    cyc_step();
    chk("reset_tx_valid", a_txv, 0);
    chk("reset_tx_flit", a_txf, 0);
    chk("reset_out_cnt", a_cnt, 0);
    chk("reset_err", a_err, 0);

    // round-robin between two posted writers
    bus.req_valid = 2'b11; bus.req_flit[0] = w0; bus.req_flit[1] = w1;
    for (int k = 0; k < 4; k++) begin
      cyc_step();
      chk("rr_grant", a_rr, (k % 2 == 0) ? 2'b01 : 2'b10);
      if (k == 1) begin
        chk("rr_first_valid", a_txv, 1);
        chk("rr_first_flit", a_txf, w0);
      end
      if (k == 2) chk("rr_second_flit", a_txf, w1);
    end
    bus.req_valid = '0;
    cyc_step();

    // read round trip from requester 1
    bus.req_valid = 2'b10; bus.req_flit[1] = rd10;
    cyc_step();
    chk("rt_grant", a_rr, 2'b10);
    bus.req_valid = '0;
    cyc_step();
    chk("rt_cnt1", a_cnt, 1);
    repeat (8) cyc_step();
    bus.noc_rx_valid = 1'b1; bus.noc_rx_flit = rs10;
    cyc_step();
    chk("rt_rsp_valid", a_rspv, 2'b10);
    chk("rt_rx_ready", a_rxr, 1);
    bus.noc_rx_valid = 1'b0;
    cyc_step();
    chk("rt_cnt0", a_cnt, 0);

    // destination lock
    bus.req_valid = 2'b01; bus.req_flit[0] = rd10;
    cyc_step();
    bus.req_valid = 2'b10; bus.req_flit[1] = rd20;
    repeat (3) begin
      cyc_step();
      chk("lock_stall", a_rr, 0);
    end
    bus.noc_rx_valid = 1'b1; bus.noc_rx_flit = rs10;
    cyc_step();
    chk("lock_retire_stall", a_rr, 0);
    chk("lock_rsp0", a_rspv, 2'b01);
    bus.noc_rx_valid = 1'b0;
    cyc_step();
    chk("lock_grant", a_rr, 2'b10);
    bus.req_valid = '0;
    cyc_step();
    chk("lock_cnt", a_cnt, 1);
    bus.noc_rx_valid = 1'b1; bus.noc_rx_flit = rs20;
    cyc_step();
    chk("lock_rsp1", a_rspv, 2'b10);
    bus.noc_rx_valid = 1'b0;
    cyc_step();
    chk("lock_cnt0", a_cnt, 0);

    // outstanding limit
    bus.req_valid = 2'b01; bus.req_flit[0] = rd10;
    repeat (4) cyc_step();
    cyc_step();
    chk("lim_stall", a_rr, 0);
    chk("lim_cnt4", a_cnt, 4);
    bus.noc_rx_valid = 1'b1; bus.noc_rx_flit = rs10;
    cyc_step();
    chk("lim_same_cycle_stall", a_rr, 0);
    chk("lim_cnt_still4", a_cnt, 4);
    bus.noc_rx_valid = 1'b0;
    cyc_step();
    chk("lim_fifth_grant", a_rr, 2'b01);
    chk("lim_cnt3", a_cnt, 3);
    bus.req_valid = '0;
    cyc_step();
    chk("lim_cnt_back4", a_cnt, 4);
    bus.noc_rx_valid = 1'b1;
    repeat (4) cyc_step();
    bus.noc_rx_valid = 1'b0;
    cyc_step();
    chk("lim_drained", a_cnt, 0);

    // backpressure (pointer now favours requester 1)
    bus.noc_tx_ready = 1'b0; bus.req_valid = 2'b11;
    bus.req_flit[0] = w0; bus.req_flit[1] = w1;
    cyc_step();
    chk("bp_load", a_rr, 2'b10);
    repeat (5) begin
      cyc_step();
      chk("bp_stall", a_rr, 0);
      chk("bp_hold_flit", a_txf, w1);
    end
    bus.noc_tx_ready = 1'b1;
    cyc_step();
    chk("bp_release", a_rr, 2'b01);
    cyc_step();
    chk("bp_order_flit", a_txf, w0);
    bus.req_valid = '0;
    cyc_step();

    // unexpected flits: no outstanding read, then wrong source while locked
    bus.noc_rx_valid = 1'b1; bus.noc_rx_flit = rs10;
    cyc_step();
    chk("unx0_rx_ready", a_rxr, 1);
    chk("unx0_rsp_valid", a_rspv, 0);
    bus.noc_rx_valid = 1'b0;
    cyc_step();
    chk("unx0_err", a_err, 1);
    cyc_step();
    chk("unx0_err_clear", a_err, 0);
    bus.req_valid = 2'b01; bus.req_flit[0] = rd10;
    cyc_step();
    bus.req_valid = '0;
    bus.noc_rx_valid = 1'b1; bus.noc_rx_flit = mkf(OP_READ_RESP, 2'd0, 2'd0, 2'd3, 2'd3, 20'h5);
    cyc_step();
    chk("unx1_rsp_valid", a_rspv, 0);
    chk("unx1_rx_ready", a_rxr, 1);
    bus.noc_rx_valid = 1'b0;
    cyc_step();
    chk("unx1_err", a_err, 1);
    chk("unx1_cnt", a_cnt, 1);
    bus.noc_rx_valid = 1'b1; bus.noc_rx_flit = rs10;
    cyc_step();
    bus.noc_rx_valid = 1'b0;
    cyc_step();

    // randomized traffic with resets between segments
    rxq.delete();
    for (int i = 0; i < N; i++) pend[i] = 0;
    for (int seg = 0; seg < 4; seg++) begin
      p_txr  = (seg == 1) ? 30 : 80;
      p_rspr = (seg == 2) ? 35 : 75;
      p_req  = (seg == 3) ? 95 : 60;
      for (int c = 0; c < 800; c++) begin
        rst = (seg > 0 && c < 2);
        drive();
        cyc_step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/yc_noc_inject_arb.md
# yc_noc_inject_arb

Injection arbiter and read-response tracker for a NoC endpoint shared by several local requesters (CPU fetch, CPU load/store, DMA). It sits between the requesters and the node's local mesh port. It grants one single-flit request per cycle onto the mesh using round-robin arbitration. It counts outstanding reads and returns each `OP_READ_RESP` to the requester that issued the matching read. In-order response return is guaranteed by a destination lock: all outstanding reads target one node, and XY routing keeps them ordered.

## Interface
- `N_REQ`, 2: number of requesters (2..8).
- `MAX_OUT`, 4: maximum outstanding reads (power of two, ≥1).
- `ID_W`, `$clog2(N_REQ)` (min 1): requester-ID width.

- `clk` in 1: single clock, all state on posedge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in N_REQ: per-requester request valid.
- `req_flit` in N_REQ × `flit_t`: per-requester request flit (`yc_noc_defs` encoding).
- `req_ready` out N_REQ: request accepted when `req_valid[i] && req_ready[i]`.
- `noc_tx_valid` out 1: flit to mesh local port.
- `noc_tx_flit` out `flit_t`: registered output flit.
- `noc_tx_ready` in 1: mesh accepts.
- `noc_rx_valid` in 1: flit from mesh local port.
- `noc_rx_flit` in `flit_t`: incoming flit.
- `noc_rx_ready` out 1: block consumes the incoming flit.
- `rsp_valid` out N_REQ: response valid to requester i.
- `rsp_flit` out `flit_t`: response flit, shared by all requesters (`noc_rx_flit` passthrough).
- `rsp_ready` in N_REQ: requester accepts response.
- `out_cnt` out `$clog2(MAX_OUT+1)`: outstanding read count.
- `err_unexpected` out 1: one-cycle pulse when an unexpected flit is dropped.

## Operation
- **Read classification:** a request is a read iff `get_opc(req_flit[i]) == OP_READ_REQ`. All other opcodes are posted and are not tracked.
- **Eligibility:** requester i is eligible when `req_valid[i]` is high and either:
  - the request is posted, or
  - the request is a read, `out_cnt < MAX_OUT`, and either `out_cnt == 0` or `{get_dst_x,get_dst_y}` equals `lock_dst`.
- **Grant:** round-robin over eligible requesters, starting at `rr_ptr`. `req_ready[i]` is high only for the granted requester, and only when the output register can load.
  - The output register can load when `!noc_tx_valid || noc_tx_ready`.
  - On acceptance, `rr_ptr <= grant+1`, wrapping modulo N_REQ.
- **Output register:** loads the granted flit. `noc_tx_valid`/`noc_tx_flit` stay stable until `noc_tx_ready`.
- **Read accept:** push the granted ID into the ID FIFO (depth MAX_OUT) and increment `out_cnt`. If `out_cnt == 0`, latch `lock_dst <= dst` of the flit.
- **Response path:** a response is expected when all of the following hold:
  - `noc_rx_valid`,
  - opcode is `OP_READ_RESP`,
  - `out_cnt > 0`,
  - `{src_x,src_y} == lock_dst`.
- **Expected response:** with `id = FIFO head`, drive `rsp_valid[id] = 1` and `noc_rx_ready = rsp_ready[id]`, both combinational. On handshake, pop the FIFO and decrement `out_cnt`.
- **Unexpected flit:** any other `noc_rx_valid` flit is consumed (`noc_rx_ready = 1`) and dropped. `err_unexpected` pulses the next cycle. FIFO and count are unchanged.
- **Simultaneous events:** a read accept and a response retire in the same cycle leave `out_cnt` unchanged, with push and pop both applied. Eligibility always uses the registered `out_cnt`, so a retire does not free a slot in the same cycle.
- **Reset:** reset mid-operation discards the output register, FIFO and count. Responses arriving after reset are treated as unexpected.

## Timing
- **Reset values:** `noc_tx_valid=0`, `noc_tx_flit=0`, `out_cnt=0`, `rr_ptr=0`, `lock_dst=0`, FIFO empty, `err_unexpected=0`. All `req_ready`, `rsp_valid` and `noc_rx_ready` are 0 while `rst` is high.
- **Request latency:** request accepted in cycle t → `noc_tx_valid` in cycle t+1.
- **Throughput:** one flit per cycle when `noc_tx_ready` is held high.
- **Response latency:** combinational, 0 cycles from `noc_rx_valid` to `rsp_valid`.
- **Error flag:** `err_unexpected` is registered, high exactly one cycle per dropped flit.
- **Ready independence:** `req_ready` depends on `req_valid` but not on `noc_rx_*`. There is no combinational path from `noc_tx_ready` to `noc_tx_valid`.

## Test plan
- **Round-robin:** N_REQ=2, both requesters send posted writes continuously, `noc_tx_ready=1` → grants alternate 0,1,0,1; one flit per cycle; first `noc_tx_valid` one cycle after reset release plus accept.
- **Read round trip:** requester 1 reads dst (1,0); the bench returns `OP_READ_RESP` src (1,0) dst (0,0) 10 cycles later → only `rsp_valid[1]` asserts; `out_cnt` goes 0→1→0.
- **Destination lock:** read 0 to (1,0) outstanding; requester 1 reads (2,0) → `req_ready[1]=0` until the response retires, then the read is granted the next cycle.
- **Outstanding limit:** four reads to (1,0) with MAX_OUT=4 → the fifth stalls with `out_cnt=4`. A response and a new request in the same cycle → count stays 4 and the fifth is granted the following cycle.
- **Backpressure:** `noc_tx_ready=0` for 5 cycles → `noc_tx_flit` stable and `req_ready` low; order is preserved after release.
- **Unexpected flit:** `OP_READ_RESP` arrives with `out_cnt=0`, or with src (3,3) while locked to (1,0) → flit consumed, `err_unexpected` high for 1 cycle, no `rsp_valid`, count unchanged.
